// File: rtl/memory_server.sv
// Latency-programmable word memory server: one request at a time, fixed LATENCY
// cycles to a one-cycle fulfilled pulse, with saturating LOAD/STORE counters.
package memory_server_pkg;
   typedef enum logic [1:0] {
      LOAD       = 2'd0,
      STORE      = 2'd1,
      CLFLUSH    = 2'd2,
      MO_UNKNOWN = 2'd3
   } memory_operation_e;
endpackage

interface reset_if;
   logic reset;
   modport sink   (input  reset);
   modport source (output reset);
endinterface

interface memory_if;
   import memory_server_pkg::*;
   logic              req_valid;
   memory_operation_e req_operation;
   logic [31:0]       req_address;
   logic [31:0]       req_store_word;
   logic [31:0]       req_loaded_word;
   logic              req_fulfilled;
   modport server (input  req_valid, req_operation, req_address, req_store_word,
                   output req_loaded_word, req_fulfilled);
   modport client (output req_valid, req_operation, req_address, req_store_word,
                   input  req_loaded_word, req_fulfilled);
endinterface

module memory_server
   import memory_server_pkg::*;
#(
   parameter int unsigned LATENCY     = 4,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clk,
   reset_if.sink       rst_if,
   memory_if.server    req_if,
   output logic [15:0] load_count,
   output logic [15:0] store_count
);

   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RESPOND = 2'd2
   } state_e;

   state_e            state, state_nxt;
   logic [7:0]        lat_cnt, lat_cnt_nxt;
   logic              capture, commit;
   memory_operation_e op_q;
   logic [IDX_W-1:0]  idx_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rd_word;

   logic [31:0]            storage [DEPTH_WORDS];
   // A word never written reads back as its own index, which gives the
   // power-up contents without an init loop; reset leaves this untouched.
   logic [DEPTH_WORDS-1:0] written = '0;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_if.req_address[31:IDX_W+2], req_if.req_address[1:0]};

   assign rd_word = written[idx_q] ? storage[idx_q] : 32'(idx_q);

   always_comb begin
      state_nxt              = state;
      lat_cnt_nxt            = lat_cnt;
      capture                = 1'b0;
      commit                 = 1'b0;
      req_if.req_fulfilled   = 1'b0;
      req_if.req_loaded_word = '0;
      case (state)
         ST_IDLE: begin
            if (req_if.req_valid) begin
               capture     = 1'b1;
               lat_cnt_nxt = LAT_M1;
               state_nxt   = (LATENCY == 1) ? ST_RESPOND : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!req_if.req_valid) begin
               state_nxt = ST_IDLE;
            end else begin
               lat_cnt_nxt = lat_cnt - 8'd1;
               if (lat_cnt == 8'd1) state_nxt = ST_RESPOND;
            end
         end
         ST_RESPOND: begin
            commit               = 1'b1;
            req_if.req_fulfilled = 1'b1;
            if (op_q == LOAD) req_if.req_loaded_word = rd_word;
            state_nxt            = ST_IDLE;
         end
         default: begin
            state_nxt              = ST_IDLE;
            req_if.req_fulfilled   = 1'bx;
            req_if.req_loaded_word = 'x;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_if.reset) begin
         state       <= ST_IDLE;
         lat_cnt     <= '0;
         load_count  <= '0;
         store_count <= '0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_cnt_nxt;
         if (commit && op_q == LOAD && load_count != '1)
            load_count <= load_count + 16'd1;
         if (commit && op_q == STORE && store_count != '1)
            store_count <= store_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         op_q    <= req_if.req_operation;
         idx_q   <= req_if.req_address[2 +: IDX_W];
         wdata_q <= req_if.req_store_word;
      end
   end

   always_ff @(posedge clk) begin
      if (commit && !rst_if.reset && op_q == STORE) begin
         storage[idx_q] <= wdata_q;
         written[idx_q] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_memory_server.sv
// Randomised self-checking bench for memory_server: two instances (LATENCY 4 and 1)
// checked against an array model of storage and counters.
module tb_memory_server;
   import memory_server_pkg::*;

   localparam int unsigned LAT_A   = 4;
   localparam int unsigned DEPTH_A = 1024;
   localparam int unsigned LAT_B   = 1;
   localparam int unsigned DEPTH_B = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   reset_if  rst ();
   memory_if bus_a ();
   memory_if bus_b ();
   logic [15:0] lc_a, sc_a, lc_b, sc_b;

   memory_server #(.LATENCY(LAT_A), .DEPTH_WORDS(DEPTH_A)) dut_a (
      .clk(clk), .rst_if(rst), .req_if(bus_a), .load_count(lc_a), .store_count(sc_a));
   memory_server #(.LATENCY(LAT_B), .DEPTH_WORDS(DEPTH_B)) dut_b (
      .clk(clk), .rst_if(rst), .req_if(bus_b), .load_count(lc_b), .store_count(sc_b));

   int passed = 0;
   int total  = 0;
   logic [31:0] mem_a [DEPTH_A];
   int exp_lc = 0;
   int exp_sc = 0;

   function automatic int unsigned widx(input logic [31:0] addr);
      return int'(addr[11:2]);
   endfunction

   // Reference semantics for one completed transaction on dut_a.
   function automatic logic [31:0] model_apply(input memory_operation_e op,
                                               input logic [31:0] addr, data);
      logic [31:0] r;
      r = '0;
      if (op == LOAD) begin
         r = mem_a[widx(addr)];
         exp_lc++;
      end else if (op == STORE) begin
         mem_a[widx(addr)] = data;
         exp_sc++;
      end
      return r;
   endfunction

   // Issue one request on dut_a, scrambling inputs after sampling; returns latency (0 on timeout).
   task automatic run_a(input memory_operation_e op, input logic [31:0] addr, data,
                        output int lat, output logic [31:0] word);
      bus_a.req_valid      = 1'b1;
      bus_a.req_operation  = op;
      bus_a.req_address    = addr;
      bus_a.req_store_word = data;
      lat  = 0;
      word = '0;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (bus_a.req_fulfilled === 1'b1) begin
            lat  = n;
            word = bus_a.req_loaded_word;
            break;
         end
         bus_a.req_address    = $urandom;
         bus_a.req_store_word = $urandom;
         bus_a.req_operation  = memory_operation_e'($urandom_range(0, 3));
      end
      bus_a.req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst.reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus_a.req_fulfilled !== 1'b0) $display("FAIL reset_fulfilled got=%b exp=0", bus_a.req_fulfilled); else passed++;
      total++; if (bus_a.req_loaded_word !== 32'h0) $display("FAIL reset_loaded got=%h exp=0", bus_a.req_loaded_word); else passed++;
      total++; if (lc_a !== 16'h0 || sc_a !== 16'h0) $display("FAIL reset_counts got=%h/%h exp=0/0", lc_a, sc_a); else passed++;
      total++; if (bus_b.req_fulfilled !== 1'b0 || lc_b !== 16'h0) $display("FAIL reset_b got=%b/%h exp=0/0", bus_b.req_fulfilled, lc_b); else passed++;
      rst.reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_load;
      int lat; logic [31:0] w, e;
      e = model_apply(LOAD, 32'h10, 32'h0);
      run_a(LOAD, 32'h10, 32'h0, lat, w);
      total++; if (lat != 4) $display("FAIL basic_latency got=%0d exp=4", lat); else passed++;
      total++; if (w !== 32'h4 || e !== 32'h4) $display("FAIL basic_word got=%h exp=4", w); else passed++;
      total++; if (lc_a !== 16'd1) $display("FAIL basic_load_count got=%0d exp=1", lc_a); else passed++;
      total++; if (bus_a.req_fulfilled !== 1'b0) $display("FAIL basic_single_pulse got=%b exp=0", bus_a.req_fulfilled); else passed++;
   endtask

   task automatic test_store_load;
      int lat; logic [31:0] w, e;
      e = model_apply(STORE, 32'h40, 32'hDEAD_BEEF);
      run_a(STORE, 32'h40, 32'hDEAD_BEEF, lat, w);
      total++; if (lat != int'(LAT_A) || w !== e) $display("FAIL store_resp got=%0d/%h exp=%0d/%h", lat, w, LAT_A, e); else passed++;
      total++; if (sc_a !== 16'(exp_sc)) $display("FAIL store_count got=%0d exp=%0d", sc_a, exp_sc); else passed++;
      e = model_apply(LOAD, 32'h40, 32'h0);
      run_a(LOAD, 32'h40, 32'h0, lat, w);
      total++; if (w !== 32'hDEAD_BEEF) $display("FAIL store_readback got=%h exp=deadbeef", w); else passed++;
      e = model_apply(LOAD, 32'h40 + 4 * DEPTH_A, 32'h0);
      run_a(LOAD, 32'h40 + 4 * DEPTH_A, 32'h0, lat, w);
      total++; if (w !== 32'hDEAD_BEEF || e !== 32'hDEAD_BEEF) $display("FAIL store_wrap got=%h exp=deadbeef", w); else passed++;
      total++; if (lc_a !== 16'(exp_lc)) $display("FAIL store_load_count got=%0d exp=%0d", lc_a, exp_lc); else passed++;
   endtask

   task automatic test_random;
      int lat; logic [31:0] w, e, addr, data;
      memory_operation_e op;
      for (int i = 0; i < 40; i++) begin
         op   = memory_operation_e'($urandom_range(0, 3));
         addr = $urandom;
         if (i % 2 == 0) addr = addr & 32'hFFFF_F03C;
         data = $urandom;
         e = model_apply(op, addr, data);
         run_a(op, addr, data, lat, w);
         total++; if (lat != int'(LAT_A)) $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, LAT_A); else passed++;
         total++; if (w !== e) $display("FAIL rand_word[%0d] op=%0d got=%h exp=%h", i, op, w, e); else passed++;
         total++; if (lc_a !== 16'(exp_lc) || sc_a !== 16'(exp_sc))
            $display("FAIL rand_counts[%0d] got=%0d/%0d exp=%0d/%0d", i, lc_a, sc_a, exp_lc, exp_sc); else passed++;
      end
   endtask

   task automatic test_abort;
      int lat, seen; logic [31:0] w, e;
      seen = 0;
      bus_a.req_valid      = 1'b1;
      bus_a.req_operation  = STORE;
      bus_a.req_address    = 32'h200;
      bus_a.req_store_word = 32'h1234_5678;
      repeat (2) @(negedge clk);
      bus_a.req_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus_a.req_fulfilled !== 1'b0) seen++;
      end
      total++; if (seen != 0) $display("FAIL abort_fulfilled got=%0d pulses exp=0", seen); else passed++;
      total++; if (sc_a !== 16'(exp_sc)) $display("FAIL abort_store_count got=%0d exp=%0d", sc_a, exp_sc); else passed++;
      e = model_apply(LOAD, 32'h200, 32'h0);
      run_a(LOAD, 32'h200, 32'h0, lat, w);
      total++; if (w !== e) $display("FAIL abort_contents got=%h exp=%h", w, e); else passed++;
   endtask

   task automatic test_reset_mid;
      int lat; logic [31:0] w, e;
      bus_a.req_valid      = 1'b1;
      bus_a.req_operation  = STORE;
      bus_a.req_address    = 32'h300;
      bus_a.req_store_word = 32'hCAFE_F00D;
      repeat (2) @(negedge clk);
      rst.reset       = 1'b1;
      bus_a.req_valid = 1'b0;
      @(negedge clk);
      total++; if (bus_a.req_fulfilled !== 1'b0 || bus_a.req_loaded_word !== 32'h0)
         $display("FAIL rstmid_outputs got=%b/%h exp=0/0", bus_a.req_fulfilled, bus_a.req_loaded_word); else passed++;
      total++; if (lc_a !== 16'h0 || sc_a !== 16'h0) $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", lc_a, sc_a); else passed++;
      rst.reset = 1'b0;
      exp_lc = 0;
      exp_sc = 0;
      @(negedge clk);
      e = model_apply(LOAD, 32'h300, 32'h0);
      run_a(LOAD, 32'h300, 32'h0, lat, w);
      total++; if (lat != int'(LAT_A)) $display("FAIL rstmid_latency got=%0d exp=%0d", lat, LAT_A); else passed++;
      total++; if (w !== e) $display("FAIL rstmid_storage got=%h exp=%h", w, e); else passed++;
      total++; if (lc_a !== 16'd1 || sc_a !== 16'd0) $display("FAIL rstmid_post_counts got=%0d/%0d exp=1/0", lc_a, sc_a); else passed++;
   endtask

   task automatic test_flush_unknown;
      int lat; logic [31:0] w, e;
      memory_operation_e ops [2];
      ops[0] = CLFLUSH;
      ops[1] = MO_UNKNOWN;
      for (int i = 0; i < 2; i++) begin
         e = model_apply(ops[i], 32'h40, 32'h5555_AAAA);
         run_a(ops[i], 32'h40, 32'h5555_AAAA, lat, w);
         total++; if (lat != int'(LAT_A) || w !== 32'h0) $display("FAIL nop_resp[%0d] got=%0d/%h exp=%0d/0", i, lat, w, LAT_A); else passed++;
         total++; if (lc_a !== 16'(exp_lc) || sc_a !== 16'(exp_sc))
            $display("FAIL nop_counts[%0d] got=%0d/%0d exp=%0d/%0d", i, lc_a, sc_a, exp_lc, exp_sc); else passed++;
      end
      e = model_apply(LOAD, 32'h40, 32'h0);
      run_a(LOAD, 32'h40, 32'h0, lat, w);
      total++; if (w !== e) $display("FAIL nop_storage got=%h exp=%h", w, e); else passed++;
   endtask

   task automatic test_back_to_back;
      int cyc, got;
      logic [31:0] w;
      cyc = 0;
      bus_b.req_valid      = 1'b1;
      bus_b.req_operation  = LOAD;
      bus_b.req_address    = 32'h100;
      bus_b.req_store_word = '0;
      for (int k = 0; k < 8; k++) begin
         got = 0;
         w   = '0;
         for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            cyc++;
            if (bus_b.req_fulfilled === 1'b1) begin
               got = 1;
               w   = bus_b.req_loaded_word;
               break;
            end
         end
         total++; if (got != 1 || cyc != 1 + 2 * k)
            $display("FAIL b2b_timing[%0d] got=%0d cycle=%0d exp cycle=%0d", k, got, cyc, 1 + 2 * k); else passed++;
         total++; if (w !== 32'h40 + 32'(k)) $display("FAIL b2b_word[%0d] got=%h exp=%h", k, w, 32'h40 + 32'(k)); else passed++;
         bus_b.req_address = 32'h100 + 32'(4 * (k + 1));
      end
      bus_b.req_valid = 1'b0;
      @(negedge clk);
      total++; if (lc_b !== 16'd8) $display("FAIL b2b_load_count got=%0d exp=8", lc_b); else passed++;
      got = 0;
      w   = '0;
      bus_b.req_valid   = 1'b1;
      bus_b.req_address = 32'h100 + 4 * DEPTH_B;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (bus_b.req_fulfilled === 1'b1) begin
            got = n;
            w   = bus_b.req_loaded_word;
            break;
         end
      end
      bus_b.req_valid = 1'b0;
      @(negedge clk);
      total++; if (got != int'(LAT_B) || w !== 32'h40) $display("FAIL b_wrap got=%0d/%h exp=%0d/40", got, w, LAT_B); else passed++;
   endtask

   initial begin
      for (int unsigned i = 0; i < DEPTH_A; i++) mem_a[i] = i;
      rst.reset            = 1'b1;
      bus_a.req_valid      = 1'b0;
      bus_a.req_operation  = LOAD;
      bus_a.req_address    = '0;
      bus_a.req_store_word = '0;
      bus_b.req_valid      = 1'b0;
      bus_b.req_operation  = LOAD;
      bus_b.req_address    = '0;
      bus_b.req_store_word = '0;
      test_reset();
      test_basic_load();
      test_store_load();
      test_random();
      test_abort();
      test_reset_mid();
      test_flush_unknown();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
